// File: rtl/uart_frame_codec_pkg.sv
// Shared definitions for the UART frame codec and the debug unit.
//   - TX serializer state encoding
//   - clog2 helper used to size counters
//   - default byte width and protocol frame lengths (4-byte command in,
//     7-byte debug record out)
package uart_frame_codec_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_RX_BYTES  = 4;
  localparam int DEFAULT_TX_BYTES  = 7;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_frame_serializer.sv
// Serialises a TX_BYTES frame LSB-byte-first through the UART TX start/done
// handshake.
// Ports:
//   i_clk, i_reset (async, active low), i_flush (abandon remaining bytes)
//   i_frame / i_frame_valid : frame offered, captured while IDLE
//   i_tx_done               : UART finished the byte in flight
//   o_tx_data / o_tx_start  : byte to send and its one-cycle start pulse
//   o_state                 : current FSM state (ready/busy derive from it)
// Handshake: a frame transfers on any cycle where the FSM is IDLE and
// i_frame_valid is high; o_frame_ready is simply (o_state == TX_IDLE).
module uart_frame_serializer
  import uart_frame_codec_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int TX_BYTES  = DEFAULT_TX_BYTES
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic [TX_BYTES*DATA_BITS-1:0] i_frame,
  input  logic                          i_frame_valid,
  input  logic                          i_tx_done,
  output logic [DATA_BITS-1:0]          o_tx_data,
  output logic                          o_tx_start,
  output tx_state_t                     o_state
);

  localparam int IW = clog2(TX_BYTES + 1);
  localparam logic [IW-1:0] LAST = IW'(TX_BYTES - 1);

  tx_state_t                     state_q, state_d;
  logic [TX_BYTES*DATA_BITS-1:0] frame_q;
  logic [IW-1:0]                 idx_q;
  logic                          flush_q;  // flush seen while a byte is in flight

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (i_frame_valid) state_d = TX_SEND;
      TX_SEND: state_d = i_flush ? TX_IDLE : TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST || flush_q || i_flush) state_d = TX_IDLE;
          else                                     state_d = TX_SEND;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= TX_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        TX_IDLE: begin
          flush_q <= 1'b0;
          if (i_frame_valid) begin
            frame_q <= i_frame;
            idx_q   <= '0;
          end
        end
        TX_WAIT: begin
          if (i_flush) flush_q <= 1'b1;
          // Shift only when moving to the next byte so o_tx_data stays put
          // through SEND and WAIT.
          if (i_tx_done && state_d == TX_SEND) begin
            frame_q <= frame_q >> DATA_BITS;
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data  = frame_q[DATA_BITS-1:0];
  assign o_tx_start = (state_q == TX_SEND);
  assign o_state    = state_q;

endmodule

// File: rtl/uart_frame_codec.sv
// Byte-to-word bridge between the UART and the debug unit.
// RX: assembles RX_BYTES bytes LSB-first into o_word, with inter-byte
//     timeout (o_rx_timeout pulse) and sticky overrun flag.
// TX: accepts a TX_BYTES frame and serialises it via uart_frame_serializer.
// Ports:
//   i_clk, i_reset (async, active low), i_flush (sync clear)
//   i_rx_data/i_rx_done, o_word/o_word_valid/i_word_ready,
//   o_rx_overrun, o_rx_timeout,
//   i_frame/i_frame_valid/o_frame_ready, o_tx_data/o_tx_start/i_tx_done,
//   o_tx_busy
// Handshake: a transfer happens on every cycle where valid and ready are both
// high; valid never waits on ready and the payload is stable while valid.
module uart_frame_codec
  import uart_frame_codec_pkg::*;
#(
  parameter int DATA_BITS      = DEFAULT_DATA_BITS,
  parameter int RX_BYTES       = DEFAULT_RX_BYTES,
  parameter int TX_BYTES       = DEFAULT_TX_BYTES,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic [DATA_BITS-1:0]          i_rx_data,
  input  logic                          i_rx_done,
  output logic [RX_BYTES*DATA_BITS-1:0] o_word,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic                          o_rx_overrun,
  output logic                          o_rx_timeout,
  input  logic [TX_BYTES*DATA_BITS-1:0] i_frame,
  input  logic                          i_frame_valid,
  output logic                          o_frame_ready,
  output logic [DATA_BITS-1:0]          o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_done,
  output logic                          o_tx_busy
);

  localparam int WW = RX_BYTES * DATA_BITS;
  localparam int KW = clog2(RX_BYTES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(RX_BYTES - 1);

  logic [KW-1:0] k_q;
  logic [WW-1:0] asm_q;
  logic [WW-1:0] word_c;     // assembly with the incoming byte merged in
  logic          last_byte;
  logic          word_free;  // output register can take a word this cycle
  logic          expire;

  always_comb begin
    word_c = asm_q;
    word_c[k_q*DATA_BITS +: DATA_BITS] = i_rx_data;
  end

  assign last_byte = (k_q == K_LAST);
  assign word_free = !o_word_valid || i_word_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      k_q          <= '0;
      asm_q        <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_rx_overrun <= 1'b0;
    end else if (i_flush) begin
      k_q          <= '0;
      o_word_valid <= 1'b0;
      o_rx_overrun <= 1'b0;
    end else begin
      // Consumption first so a word completing in the same cycle overrides.
      if (o_word_valid && i_word_ready) o_word_valid <= 1'b0;
      if (i_rx_done) begin
        asm_q <= word_c;
        if (last_byte) begin
          k_q <= '0;
          if (word_free) begin
            o_word       <= word_c;
            o_word_valid <= 1'b1;
          end else begin
            o_rx_overrun <= 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
      end else if (expire) begin
        k_q <= '0;
      end
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_q;
    logic          pulse_q;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire = (k_q != '0) && !i_rx_done && !i_flush && (tcnt_q == T_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        tcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= expire;
        if (i_flush || i_rx_done || k_q == '0 || tcnt_q == T_LAST) tcnt_q <= '0;
        else                                                       tcnt_q <= tcnt_q + 1'b1;
      end
    end

    assign o_rx_timeout = pulse_q;
  end else begin : g_no_timeout
    assign expire       = 1'b0;
    assign o_rx_timeout = 1'b0;
  end

  tx_state_t tx_state;

  uart_frame_serializer #(
    .DATA_BITS (DATA_BITS),
    .TX_BYTES  (TX_BYTES)
  ) u_serializer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_flush       (i_flush),
    .i_frame       (i_frame),
    .i_frame_valid (i_frame_valid),
    .i_tx_done     (i_tx_done),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .o_state       (tx_state)
  );

  assign o_frame_ready = (tx_state == TX_IDLE);
  assign o_tx_busy     = (tx_state != TX_IDLE);

endmodule

// File: doc/uart_frame_codec.md
Name: uart_frame_codec

Overview:
- Byte-to-word bridge between the UART byte receiver/transmitter and the debug unit.
- RX side assembles RX_BYTES consecutive bytes, LSB-first, into one command/instruction word. It has an inter-byte timeout, an overrun flag and a valid/ready output.
- TX side takes a TX_BYTES frame (e.g. 7-byte debug record) under valid/ready and serialises it byte by byte, LSB-first, through the UART TX start/done handshake.
- Generalises the fixed 4-byte-in / 7-byte-out protocol to arbitrary byte width and frame lengths.

Parameters:
DATA_BITS, 8, bits per UART byte
RX_BYTES, 4, bytes per received word (>=1)
TX_BYTES, 7, bytes per transmitted frame (>=1)
TIMEOUT_CYCLES, 16384, clocks allowed between RX bytes of one word; 0 disables timeout

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_flush  in  1  synchronous clear (RX state, overrun, pending TX bytes)
i_rx_data  in  DATA_BITS  byte from UART receiver
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
o_word  out  RX_BYTES*DATA_BITS  assembled word
o_word_valid  out  1  o_word holds an unconsumed word
i_word_ready  in  1  consumer accepts o_word
o_rx_overrun  out  1  sticky: completed word dropped
o_rx_timeout  out  1  one-cycle pulse: partial word discarded
i_frame  in  TX_BYTES*DATA_BITS  frame to send
i_frame_valid  in  1  frame offered
o_frame_ready  out  1  serializer idle, frame accepted this cycle if valid
o_tx_data  out  DATA_BITS  byte to UART transmitter
o_tx_start  out  1  one-cycle pulse, start sending o_tx_data
i_tx_done  in  1  one-cycle pulse, UART finished a byte
o_tx_busy  out  1  frame in progress

Behaviour:
- Reset values (asynchronous, while i_reset=0):
  - o_word=0, o_word_valid=0, o_rx_overrun=0, o_rx_timeout=0.
  - o_tx_data=0, o_tx_start=0, o_tx_busy=0.
  - TX FSM=IDLE, so o_frame_ready=1.
  - All counters 0; any partial word or frame is lost.
- RX assembly:
  - On i_rx_done, byte index k (0..RX_BYTES-1) is written to assembly bits [k*DATA_BITS +: DATA_BITS], then k increments.
  - On byte k=RX_BYTES-1:
    - If the output register is free, or i_word_ready is high the same cycle: o_word loads and o_word_valid=1 the next cycle (latency 1 clock from the last i_rx_done). k wraps to 0.
    - Otherwise the new word is dropped, o_rx_overrun=1 (sticky until i_flush or reset), k wraps to 0.
  - o_word_valid falls the cycle after i_word_ready=1 with valid=1, unless a new word loads that same cycle.
  - o_word is stable while o_word_valid=1.
- RX timeout:
  - Counter clears on every i_rx_done and counts while 0<k.
  - Reaching TIMEOUT_CYCLES discards the partial word: k=0, o_rx_timeout pulses 1 cycle.
  - If i_rx_done coincides with expiry, the byte wins: no timeout pulse.
- TX FSM, states IDLE, SEND, WAIT:
  - IDLE: o_frame_ready=1. If i_frame_valid, capture i_frame, index=0, go to SEND.
  - SEND: o_tx_start=1 for exactly this cycle, o_tx_data=byte[index]. Go to WAIT.
  - WAIT: on i_tx_done, if index==TX_BYTES-1 go to IDLE, else index++ and go to SEND.
  - o_tx_data is held stable through SEND and WAIT. i_tx_done is ignored outside WAIT.
- TX timing:
  - Frame accept at cycle N gives first o_tx_start at N+1.
  - i_tx_done at cycle M gives next o_tx_start at M+1.
  - Frame complete: IDLE at M+1 after the last done; a new frame is accepted in that cycle.
- o_tx_busy=1 in SEND/WAIT.
- i_flush: RX k=0, o_word_valid=0, o_rx_overrun=0, timeout counter cleared. TX:
  - In SEND: go to IDLE after issuing the current start.
  - In WAIT: wait for i_tx_done, then go to IDLE. The byte in flight is never truncated.
- TIMEOUT_CYCLES=0: counter logic removed, o_rx_timeout tied 0.
- Width rules: counter widths via clog2 of (bytes+1) and (TIMEOUT_CYCLES+1). No arithmetic overflow paths.

Decomposition:
- Shared package holds:
  - TX state encoding (IDLE, SEND, WAIT).
  - clog2 helper.
  - Default DATA_BITS and protocol frame lengths (4, 7), shared with the debug unit.
- Natural sub-module: uart_frame_serializer (TX FSM + frame shift register). RX assembly stays in the top.

Test Plan:
- Reset then RX bytes 0xD3,0x1B,0x04,0x20 (4 done pulses, ready=1) -> o_word=0x20041BD3, o_word_valid high 1 cycle after 4th done, low the cycle after acceptance.
- RX 2 bytes, then idle TIMEOUT_CYCLES (set to 50) -> o_rx_timeout single pulse; next 4 bytes 0x11,0x22,0x33,0x44 -> o_word=0x44332211.
- Hold i_word_ready=0, send 8 bytes -> first word held, o_rx_overrun=1; i_flush -> overrun and valid cleared.
- Offer frame 0x0706050403_0201 with UART model done 10 cycles after each start -> 7 start pulses carrying 0x01..0x07 in order. o_frame_ready=0 throughout; back to 1 one cycle after the 7th done.
- Assert i_reset low while in WAIT with index 3 -> all outputs at reset values immediately. After release a new frame starts from byte 0.
- Parameter sweep: RX_BYTES=1, TX_BYTES=1, DATA_BITS=7 -> single-byte words/frames pass through, o_word width 7.
